tq_mcm4_pipe: RTL and testbench

//   Parametrised, pipelined 4-point HEVC partial-butterfly multiplier stage (forward DCT / inverse DCT).

---
 rtl/tq_pkg.sv | 18 +
 rtl/tq_pipe_slice.sv | 28 ++
 rtl/tq_mcm4_pipe.sv | 159 +++++++++++++++
 tb/tb_tq_mcm4_pipe.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tq_pkg.sv
// Shared constants, block-row state type and rounding helper for the tq multiplier pipeline.
package tq_pkg;

    localparam int TQ_C64 = 64;
    localparam int TQ_C83 = 83;
    localparam int TQ_C36 = 36;

    typedef enum logic [1:0] {ROW0, ROW1, ROW2, ROW3} row_t;

    // Round-half-up arithmetic right shift on a sign-extended 64-bit value.
    function automatic logic signed [63:0] rnd_shift(input logic signed [63:0] value,
                                                     input int                 shift);
        logic signed [63:0] bias;
        bias = 64'sd1 <<< (shift - 1);
        return (value + bias) >>> shift;
    endfunction

endpackage

// File: rtl/tq_pipe_slice.sv
// Single valid/ready pipeline register; loads when empty or when its content drains this cycle.
module tq_pipe_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid)
                out_data <= in_data;
        end
    end

endmodule

// File: rtl/tq_mcm4_pipe.sv
// 4-point HEVC partial-butterfly multiplier stage with 4-row block framing.
// Optional macro TQ_MCM4_ROUND_EN adds a rounding/shift output stage (latency 3 instead of 2).
module tq_mcm4_pipe
    import tq_pkg::*;
#(
    parameter int IN_W  = 20,
    parameter int OUT_W = IN_W + 8,
    parameter int SHIFT = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             inverse,
    input  logic [IN_W-1:0]  i_0,
    input  logic [IN_W-1:0]  i_1,
    input  logic [IN_W-1:0]  i_2,
    input  logic [IN_W-1:0]  i_3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [OUT_W-1:0] o_0,
    output logic [OUT_W-1:0] o_1,
    output logic [OUT_W-1:0] o_2,
    output logic [OUT_W-1:0] o_3
);

    localparam int P1_W = 6 * OUT_W + 2;
    localparam int P2_W = 4 * OUT_W + 1;

    localparam logic signed [OUT_W-1:0] C64 = OUT_W'(TQ_C64);
    localparam logic signed [OUT_W-1:0] C83 = OUT_W'(TQ_C83);
    localparam logic signed [OUT_W-1:0] C36 = OUT_W'(TQ_C36);

    if (OUT_W < IN_W + 8 || SHIFT < 1 || SHIFT > OUT_W - 2) begin : g_param_check
        $error("tq_mcm4_pipe: OUT_W must be >= IN_W+8 and SHIFT in 1..OUT_W-2");
    end

    row_t row;
    logic blk_mode;
    logic cur_mode;
    logic accept;

    logic signed [OUT_W-1:0] x0, x1, x2, x3;
    logic [P1_W-1:0] data_p0, data_p1;
    logic            vld_p1, rdy_p2;

    logic                    mode_p1, last_p1;
    logic signed [OUT_W-1:0] a64_0, a64_1, a36_2, a83_2, a36_3, a83_3;
    logic signed [OUT_W-1:0] s0, s1, s2, s3;
    logic [P2_W-1:0]         sum_p1, data_p2;
    logic                    vld_p2, rdy_out;

    logic [P2_W-1:0] data_out;
    logic            vld_out;

    assign accept   = in_valid && in_ready;
    assign cur_mode = (row == ROW0) ? inverse : blk_mode;

    // Block framing: mode is captured on the first row and held for the rest of the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            row      <= ROW0;
            blk_mode <= 1'b0;
        end else if (accept) begin
            if (row == ROW0)
                blk_mode <= inverse;
            row <= row_t'(row + 2'd1);
        end
    end

    // Stage 0 -> 1: full-precision products, mode and last flag
    assign x0 = OUT_W'($signed(i_0));
    assign x1 = OUT_W'($signed(i_1));
    assign x2 = OUT_W'($signed(i_2));
    assign x3 = OUT_W'($signed(i_3));

    assign data_p0 = {cur_mode, (row == ROW3),
                      x0 * C64, x1 * C64, x2 * C36, x2 * C83, x3 * C36, x3 * C83};

    tq_pipe_slice #(.W(P1_W)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (data_p0),
        .out_valid (vld_p1),
        .out_ready (rdy_p2),
        .out_data  (data_p1)
    );

    // Stage 1 -> 2: butterfly sums and differences
    assign mode_p1 = data_p1[P1_W-1];
    assign last_p1 = data_p1[P1_W-2];
    assign a64_0   = $signed(data_p1[6*OUT_W-1 -: OUT_W]);
    assign a64_1   = $signed(data_p1[5*OUT_W-1 -: OUT_W]);
    assign a36_2   = $signed(data_p1[4*OUT_W-1 -: OUT_W]);
    assign a83_2   = $signed(data_p1[3*OUT_W-1 -: OUT_W]);
    assign a36_3   = $signed(data_p1[2*OUT_W-1 -: OUT_W]);
    assign a83_3   = $signed(data_p1[OUT_W-1:0]);

    assign s0 = a64_0 + a64_1;
    assign s1 = a64_0 - a64_1;
    assign s2 = mode_p1 ? (a36_2 - a83_3) : (a36_2 + a83_3);
    assign s3 = mode_p1 ? (a83_2 + a36_3) : (a36_3 - a83_2);

    assign sum_p1 = {last_p1, s0, s1, s2, s3};

    tq_pipe_slice #(.W(P2_W)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (vld_p1),
        .in_ready  (rdy_p2),
        .in_data   (sum_p1),
        .out_valid (vld_p2),
        .out_ready (rdy_out),
        .out_data  (data_p2)
    );

`ifdef TQ_MCM4_ROUND_EN
    function automatic logic [OUT_W-1:0] rnd_w(input logic [OUT_W-1:0] v);
        logic signed [63:0] t;
        t = rnd_shift(64'($signed(v)), SHIFT);
        return t[OUT_W-1:0];
    endfunction

    logic [P2_W-1:0] rnd_p2;

    // Stage 2 -> 3: round-half-up and arithmetic shift of each result
    assign rnd_p2 = {data_p2[P2_W-1],
                     rnd_w(data_p2[4*OUT_W-1 -: OUT_W]),
                     rnd_w(data_p2[3*OUT_W-1 -: OUT_W]),
                     rnd_w(data_p2[2*OUT_W-1 -: OUT_W]),
                     rnd_w(data_p2[OUT_W-1:0])};

    tq_pipe_slice #(.W(P2_W)) u_s3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (vld_p2),
        .in_ready  (rdy_out),
        .in_data   (rnd_p2),
        .out_valid (vld_out),
        .out_ready (out_ready),
        .out_data  (data_out)
    );
`else
    assign rdy_out  = out_ready;
    assign vld_out  = vld_p2;
    assign data_out = data_p2;
`endif

    assign out_valid = vld_out;
    assign out_last  = data_out[P2_W-1];
    assign o_0       = data_out[4*OUT_W-1 -: OUT_W];
    assign o_1       = data_out[3*OUT_W-1 -: OUT_W];
    assign o_2       = data_out[2*OUT_W-1 -: OUT_W];
    assign o_3       = data_out[OUT_W-1:0];

endmodule

// File: tb/tb_tq_mcm4_pipe.sv
// Self-checking bench for tq_mcm4_pipe: queue-based reference model plus literal expectations.
module tb_tq_mcm4_pipe;

    localparam int IN_W  = 20;
    localparam int OUT_W = IN_W + 8;
    localparam int SHIFT = 7;
`ifdef TQ_MCM4_ROUND_EN
    localparam int LAT = 3;
    localparam longint F0 = 2,       F1 = 0, F2 = 3,      F3 = -1;
    localparam longint V0 = 2,       V1 = 0, V2 = -2,     V3 = 3;
    localparam longint X0 = -524288, X1 = 0, X2 = 487423, X3 = -192512;
`else
    localparam int LAT = 2;
    localparam longint F0 = 192,       F1 = -64, F2 = 440,      F3 = -105;
    localparam longint V0 = 192,       V1 = -64, V2 = -224,     V3 = 393;
    localparam longint X0 = -67108864, X1 = 0,   X2 = 62390153, X3 = -24641489;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             inverse;
    logic [IN_W-1:0]  i_0, i_1, i_2, i_3;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [OUT_W-1:0] o_0, o_1, o_2, o_3;

    tq_mcm4_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inverse   (inverse),
        .i_0       (i_0),
        .i_1       (i_1),
        .i_2       (i_2),
        .i_3       (i_3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .o_0       (o_0),
        .o_1       (o_1),
        .o_2       (o_2),
        .o_3       (o_3)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint o0, o1, o2, o3;
        bit     last;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    int   row_m = 0;
    bit   mode_m = 1'b0;
    bit   stall = 1'b0;
    bit   saw_block = 1'b0;
    logic [OUT_W-1:0] h0, h1, h2, h3;
    logic hl;
    int   ready_mode = 0;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic longint sxo(input logic [OUT_W-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint sxi(input logic [IN_W-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint rnd(input longint v);
`ifdef TQ_MCM4_ROUND_EN
        return (v + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
`else
        return v;
`endif
    endfunction

    function automatic exp_t model(input longint a0, a1, a2, a3, input bit inv, input bit last);
        exp_t e;
        e.o0   = rnd(64 * (a0 + a1));
        e.o1   = rnd(64 * (a0 - a1));
        e.o2   = rnd(inv ? 36 * a2 - 83 * a3 : 36 * a2 + 83 * a3);
        e.o3   = rnd(inv ? 83 * a2 + 36 * a3 : 36 * a3 - 83 * a2);
        e.last = last;
        return e;
    endfunction

    // Scoreboard: predicts on accept, checks on drain, checks hold while stalled.
    always @(negedge clk) begin
        exp_t e;
        bit   m;
        if (rst) begin
            q.delete();
            row_m  = 0;
            mode_m = 1'b0;
            stall  = 1'b0;
        end else begin
            if (stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_o0", o_0, h0);
                chk("hold_o1", o_1, h1);
                chk("hold_o2", o_2, h2);
                chk("hold_o3", o_3, h3);
                chk("hold_last", out_last, hl);
            end
            if (out_valid && out_ready) begin
                chk("beat_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("o0", sxo(o_0), e.o0);
                    chk("o1", sxo(o_1), e.o1);
                    chk("o2", sxo(o_2), e.o2);
                    chk("o3", sxo(o_3), e.o3);
                    chk("last", out_last, e.last);
                end
            end
            stall = out_valid && !out_ready;
            h0 = o_0; h1 = o_1; h2 = o_2; h3 = o_3; hl = out_last;
            if (in_valid && !in_ready)
                saw_block = 1'b1;
            if (in_valid && in_ready) begin
                m = (row_m == 0) ? inverse : mode_m;
                if (row_m == 0)
                    mode_m = inverse;
                q.push_back(model(sxi(i_0), sxi(i_1), sxi(i_2), sxi(i_3), m, row_m == 3));
                row_m = (row_m + 1) % 4;
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic send(input logic [IN_W-1:0] a0, a1, a2, a3, input logic inv);
        int n  = 0;
        bit ok = 1'b0;
        in_valid = 1'b1;
        i_0 = a0; i_1 = a1; i_2 = a2; i_3 = a3;
        inverse = inv;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("send_accepted", ok, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_chk(input logic [IN_W-1:0] a0, a1, a2, a3, input logic inv,
                            input longint e0, e1, e2, e3, input logic el);
        int n = 0;
        send(a0, a1, a2, a3, inv);
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, LAT - 1);
        chk("lit_o0", sxo(o_0), e0);
        chk("lit_o1", sxo(o_1), e1);
        chk("lit_o2", sxo(o_2), e2);
        chk("lit_o3", sxo(o_3), e3);
        chk("lit_last", out_last, el);
    endtask

    task automatic rand_beat();
        send(IN_W'($urandom), IN_W'($urandom), IN_W'($urandom), IN_W'($urandom),
             1'($urandom_range(0, 1)));
    endtask

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        inverse = 1'b0;
        i_0 = '0; i_1 = '0; i_2 = '0; i_3 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_o0", o_0, 0);
        chk("rst_o3", o_3, 0);
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Forward block
        for (int r = 0; r < 4; r++)
            send_chk(1, 2, 3, 4, 1'b0, F0, F1, F2, F3, r == 3);

        // Inverse latched on row 0; toggling later rows has no effect
        for (int r = 0; r < 4; r++)
            send_chk(1, 2, 3, 4, (r == 0) ? 1'b1 : 1'(r % 2), V0, V1, V2, V3, r == 3);

        // Extremes
        for (int r = 0; r < 4; r++)
            send_chk(20'h80000, 20'h80000, 20'h7FFFF, 20'h7FFFF, 1'b0, X0, X1, X2, X3, r == 3);

        // Backpressure mid-stream
        saw_block = 1'b0;
        fork
            begin
                for (int b = 0; b < 8; b++)
                    rand_beat();
            end
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                ready_mode = 2;
                repeat (5) @(posedge clk);
                @(negedge clk);
                ready_mode = 0;
            end
        join
        n = 0;
        while (q.size() > 0 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_drained", q.size(), 0);
        chk("bp_in_ready_dropped", saw_block, 1);

        // Reset in the middle of a block
        send(5, 6, 7, 8, 1'b1);
        send(9, 10, 11, 12, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_o0", o_0, 0);
        chk("mid_rst_o1", o_1, 0);
        chk("mid_rst_o2", o_2, 0);
        chk("mid_rst_o3", o_3, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        for (int r = 0; r < 4; r++)
            send_chk(1, 2, 3, 4, 1'b0, F0, F1, F2, F3, r == 3);

        // Randomized traffic with random backpressure and input gaps
        ready_mode = 1;
        for (int b = 0; b < 300; b++) begin
            rand_beat();
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        ready_mode = 0;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("final_drained", q.size(), 0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
